// File: rtl/hazard_scheduler.sv
// In-order pipeline hazard controller: tracks EX/MEM/WB destinations, raises the
// ID stall for load-use and multi-cycle EX ops, and drives forwarding selects.
module hazard_scheduler #(
  parameter int LONG_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_long,
  input  logic       flush,
  output logic       stall,
  output logic       ex_hold,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       id_wb_hit_rs,
  output logic       id_wb_hit_rt
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [3:0] LONG_LOAD = 4'(LONG_LAT - 1);

  // Write-port view of an in-flight instruction.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwrite;
  } wr_t;

  typedef struct packed {
    wr_t        wr;
    logic       memread;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } ex_rec_t;

  ex_rec_t    ex_q;
  wr_t        mem_q;
  logic       mem_memread_q;
  wr_t        wb_q;
  logic [3:0] cnt;

  ex_rec_t id_rec;
  logic    busy;
  logic    lu;
  logic    issue;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic is_writer(input wr_t r);
    return r.valid && r.regwrite && (r.dest != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic       ex_valid,
    input logic       uses,
    input logic [4:0] src,
    input wr_t        mem,
    input logic       mem_load,
    input wr_t        wb
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (ex_valid && uses) begin
      if (is_writer(mem) && !mem_load && (mem.dest == src)) sel = FWD_MEM;
      else if (is_writer(wb) && (wb.dest == src))           sel = FWD_WB;
    end
    return sel;
  endfunction

  assign busy = (cnt != 4'd0);

  assign lu = id_valid && is_writer(ex_q.wr) && ex_q.memread &&
              ((id_uses_rs && (id_rs == ex_q.wr.dest)) ||
               (id_uses_rt && (id_rt == ex_q.wr.dest)));

  assign stall   = id_valid && (busy || lu);
  assign issue   = id_valid && !stall && !flush;
  assign ex_hold = busy;

  assign fwd_a = fwd_sel(ex_q.wr.valid, ex_q.uses_rs, ex_q.rs, mem_q, mem_memread_q, wb_q);
  assign fwd_b = fwd_sel(ex_q.wr.valid, ex_q.uses_rt, ex_q.rt, mem_q, mem_memread_q, wb_q);

  assign id_wb_hit_rs = is_writer(wb_q) && id_uses_rs && (wb_q.dest == id_rs);
  assign id_wb_hit_rt = is_writer(wb_q) && id_uses_rt && (wb_q.dest == id_rt);

  // NOTE: every field gets a value on every path so no latch is inferred.
  always_comb begin
    id_rec             = '0;
    id_rec.wr.valid    = 1'b1;
    id_rec.wr.dest     = id_rd;
    id_rec.wr.regwrite = id_regwrite;
    id_rec.memread     = id_memread;
    id_rec.rs          = id_rs;
    id_rec.rt          = id_rt;
    id_rec.uses_rs     = id_uses_rs;
    id_rec.uses_rt     = id_uses_rt;
  end

  // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      mem_memread_q <= 1'b0;
      wb_q          <= '0;
      cnt           <= 4'd0;
    end else if (busy) begin
      // Long op stays in EX; the slots behind it drain as bubbles.
      mem_q         <= '0;
      mem_memread_q <= 1'b0;
      wb_q          <= mem_q;
      cnt           <= cnt - 4'd1;
    end else begin
      ex_q          <= issue ? id_rec : '0;
      mem_q         <= ex_q.wr;
      mem_memread_q <= ex_q.memread;
      wb_q          <= mem_q;
      cnt           <= (issue && id_long) ? LONG_LOAD : 4'd0;
    end
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

In-order pipeline hazard controller for the 32-bit CPU. It tracks the destination register of every instruction in EX, MEM and WB and raises the ID-stage stall for load-use hazards and for multi-cycle EX operations. It also drives the EX-stage forwarding selects and the ID-stage write-back bypass hits that the forwarding muxes consume. All outputs are combinational functions of registered state plus current ID inputs.

## Interface
- LONG_LAT, 4, total EX occupancy in cycles of a long (mul/div) op; legal 2..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs, id_rt  in  5  ID source register numbers.
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt.
- id_rd  in  5  ID destination register.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_memread  in  1  ID instruction is a load.
- id_long  in  1  ID instruction is a long EX op.
- flush  in  1  kill the ID instruction (taken branch resolved).
- stall  out  1  freeze PC and IF/ID; ID instruction not issued.
- ex_hold  out  1  hold EX pipeline register; insert bubble into MEM.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 MEM result, 01 WB result.
- id_wb_hit_rs, id_wb_hit_rt  out  1  WB write targets ID rs / rt this cycle (regfile bypass).

## Operation
- Stage records EX, MEM, WB: {valid, dest[4:0], regwrite, memread}; EX also keeps {rs, rt, uses_rs, uses_rt}.
- "Writer" = valid && regwrite && dest != 0. Register 0 never matches anything.
- busy = (cnt != 0); cnt is 4 bits.
- ex_hold = busy.
- Load-use: lu = id_valid && EX is writer && EX.memread && ((id_uses_rs && id_rs==EX.dest) || (id_uses_rt && id_rt==EX.dest)).
- stall = id_valid && (busy || lu).
- issue = id_valid && !stall && !flush.
- Per clock, priority reset > hold > normal:
  - ex_hold=1: EX unchanged, MEM <- bubble, WB <- MEM, cnt <- cnt-1.
  - else: EX <- ID record if issue, else bubble; MEM <- EX; WB <- MEM; cnt <- (issue && id_long) ? LONG_LAT-1 : 0.
- flush while ex_hold=1 only suppresses issue. The held long op is never killed.
- fwd_a = 10 if MEM is writer, !MEM.memread, EX.uses_rs and MEM.dest==EX.rs. Else 01 if WB is writer and WB.dest==EX.rs. Else 00. MEM has priority. EX invalid -> 00.
- fwd_b: same rule with rt.
- A load in MEM never forwards. lu guarantees the consumer meets it in WB.
- id_wb_hit_rs = WB is writer && id_uses_rs && WB.dest==id_rs. id_wb_hit_rt analogous.

## Timing
- Reset: all stage valids 0, cnt 0. Hence stall=0, ex_hold=0, fwd_a=fwd_b=00, id_wb_hit_*=0 while reset is high and after release. No cycle of latency on release.
- stall, ex_hold, fwd_*, id_wb_hit_* are same-cycle combinational. No register on outputs.
- Load-use costs exactly 1 stall cycle. The next cycle the consumer issues; in EX it sees the load in WB -> fwd=01.
- Long op issued at edge ending cycle N occupies EX cycles N+1..N+LONG_LAT. stall (if id_valid) and ex_hold are high in cycles N+1..N+LONG_LAT-1, exactly LONG_LAT-1 cycles. The op moves to MEM at the edge ending N+LONG_LAT.
- A second long op issued the cycle busy drops reloads cnt. There are no idle gaps.
- Reset asserted mid-busy clears cnt and all stages immediately. The long op is lost.
- flush and stall in the same cycle: stall is still reported, EX gets a bubble.

## Test plan
- Reset: assert reset with id_valid=1, id_memread=1 pending -> all outputs 0; stages empty after release.
- ALU chain: issue add r3<-..; then sub reads r3 -> no stall; sub in EX shows fwd_a=10. Third instr reads r3 -> fwd=01 in EX, id_wb_hit_rs=1 when the add is in WB.
- Load-use: lw r5; then add uses rt=r5 -> stall=1 for one cycle, MEM gets bubble; the add in EX sees fwd_b=01. Same with dest r0 -> no stall, fwd 00.
- Long op, LONG_LAT=4: issue mul r7 then id_valid=1 continuously -> stall and ex_hold high 3 cycles; mul reaches MEM on 4th edge; dependent reader then gets fwd=10.
- Flush: flush=1 with id_valid=1 and no hazard -> EX bubble, fwd 00 next cycle. flush during busy -> long op still reaches MEM on schedule.
- Reset mid-busy: assert reset in 2nd busy cycle -> stall/ex_hold drop immediately, cnt=0, no stale forwarding after release.
